// File: rtl/lpc_host_ctrl.sv
// rtl/lpc_host_ctrl.sv - LPC host cycle generator (I/O, memory, TPM-start read/write cycles)
module lpc_host_ctrl #(
    parameter int SYNC_TIMEOUT  = 32,
    parameter int LWAIT_TIMEOUT = 1024,
    parameter int NORESP_CYCLES = 3,
    parameter int ABORT_CYCLES  = 4,
    parameter bit MEM_EN        = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic        req_tpm_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        busy_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i
);

    // Both wait counters share the long-wait width so neither can wrap before its limit.
    localparam int WAIT_W = $clog2(LWAIT_TIMEOUT + 1);
    localparam int NR_W   = $clog2(NORESP_CYCLES + 1);
    localparam int AB_W   = $clog2(ABORT_CYCLES + 1);

    localparam logic [WAIT_W-1:0] SWAIT_MAX = WAIT_W'(SYNC_TIMEOUT);
    localparam logic [WAIT_W-1:0] LWAIT_MAX = WAIT_W'(LWAIT_TIMEOUT);
    localparam logic [NR_W-1:0]   NR_LAST   = NR_W'(NORESP_CYCLES - 1);
    localparam logic [AB_W-1:0]   AB_LAST   = AB_W'(ABORT_CYCLES - 1);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_SYNERR = 2'b01;
    localparam logic [1:0] ST_NORESP = 2'b10;
    localparam logic [1:0] ST_TMO    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCDIR, S_ADDR, S_DATA_LO, S_DATA_HI, S_TAR1, S_TAR2,
        S_SYNC, S_RD_LO, S_RD_HI, S_PTAR1, S_PTAR2, S_ABORT, S_ABORT_END, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic              write_q;
    logic              mem_q;
    logic              tpm_q;
    logic [31:0]       addr_q;
    logic [7:0]        data_q;
    logic [2:0]        nib_q;
    logic [WAIT_W-1:0] swait_q;
    logic [WAIT_W-1:0] lwait_q;
    logic [NR_W-1:0]   noresp_q;
    logic [AB_W-1:0]   abort_cnt_q;
    logic [1:0]        status_q;
    logic [7:0]        rdata_q;
    logic [7:0]        rsp_data_q;
    logic [1:0]        rsp_status_q;

    logic accept;
    logic sync_go, sync_err, sync_short, sync_long, sync_bad;
    logic abort_noresp, abort_tmo, abort_any;
    logic load_rsp;
    logic [3:0] addr_nib;

    // A new command may be taken while idle or in the response cycle, never during reset.
    assign req_ready_o  = !rst_i && (state_q == S_IDLE || state_q == S_RESP);
    assign accept       = req_valid_i && req_ready_o;
    assign rsp_valid_o  = (state_q == S_RESP);
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_RESP);
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign load_rsp     = (state_d == S_RESP) && (state_q != S_RESP);

    // Classify the SYNC nibble and decide whether this sample forces an abort.
    always_comb begin
        sync_go    = 1'b0;
        sync_err   = 1'b0;
        sync_short = 1'b0;
        sync_long  = 1'b0;
        sync_bad   = 1'b0;
        case (lad_i)
            4'b0000: sync_go    = 1'b1;
            4'b1010: begin
                sync_go  = 1'b1;
                sync_err = 1'b1;
            end
            4'b0101: sync_short = 1'b1;
            4'b0110: sync_long  = 1'b1;
            default: sync_bad   = 1'b1;
        endcase
        abort_noresp = sync_bad && (noresp_q >= NR_LAST);
        abort_tmo    = (sync_short && (swait_q >= SWAIT_MAX)) ||
                       (sync_long  && (lwait_q >= LWAIT_MAX));
        abort_any    = abort_noresp || abort_tmo;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing, one LAD nibble per state visit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_START;
            S_START:     state_d = S_CYCDIR;
            S_CYCDIR:    state_d = S_ADDR;
            S_ADDR:      if (nib_q == 3'd0) state_d = write_q ? S_DATA_LO : S_TAR1;
            S_DATA_LO:   state_d = S_DATA_HI;
            S_DATA_HI:   state_d = S_TAR1;
            S_TAR1:      state_d = S_TAR2;
            S_TAR2:      state_d = S_SYNC;
            S_SYNC: begin
                if (sync_go) begin
                    state_d = write_q ? S_PTAR1 : S_RD_LO;
                end else if (abort_any) begin
                    state_d = S_ABORT;
                end
            end
            S_RD_LO:     state_d = S_RD_HI;
            S_RD_HI:     state_d = S_PTAR1;
            S_PTAR1:     state_d = S_PTAR2;
            S_PTAR2:     state_d = S_RESP;
            S_ABORT:     if (abort_cnt_q == AB_LAST) state_d = S_ABORT_END;
            S_ABORT_END: state_d = S_RESP;
            S_RESP:      state_d = accept ? S_START : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Bus drive per state; the address nibble is selected MSB first by the down-counter.
    always_comb begin
        lframe_o = 1'b1;
        lad_o    = 4'hF;
        lad_oe_o = 1'b0;
        case (nib_q)
            3'd7:    addr_nib = addr_q[31:28];
            3'd6:    addr_nib = addr_q[27:24];
            3'd5:    addr_nib = addr_q[23:20];
            3'd4:    addr_nib = addr_q[19:16];
            3'd3:    addr_nib = addr_q[15:12];
            3'd2:    addr_nib = addr_q[11:8];
            3'd1:    addr_nib = addr_q[7:4];
            default: addr_nib = addr_q[3:0];
        endcase
        case (state_q)
            S_START: begin
                lframe_o = 1'b0;
                lad_oe_o = 1'b1;
                lad_o    = tpm_q ? 4'b0101 : 4'b0000;
            end
            S_CYCDIR: begin
                lad_oe_o = 1'b1;
                lad_o    = {1'b0, mem_q, write_q, 1'b0};
            end
            S_ADDR: begin
                lad_oe_o = 1'b1;
                lad_o    = addr_nib;
            end
            S_DATA_LO: begin
                lad_oe_o = 1'b1;
                lad_o    = data_q[3:0];
            end
            S_DATA_HI: begin
                lad_oe_o = 1'b1;
                lad_o    = data_q[7:4];
            end
            S_TAR1: begin
                lad_oe_o = 1'b1;
            end
            S_ABORT: begin
                lframe_o = 1'b0;
                lad_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture, SYNC counters, read data capture and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q      <= 1'b0;
            mem_q        <= 1'b0;
            tpm_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            nib_q        <= '0;
            swait_q      <= '0;
            lwait_q      <= '0;
            noresp_q     <= '0;
            abort_cnt_q  <= '0;
            status_q     <= ST_OK;
            rdata_q      <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            if (accept) begin
                write_q  <= req_write_i;
                mem_q    <= MEM_EN && req_mem_i;
                tpm_q    <= req_tpm_i;
                addr_q   <= req_addr_i;
                data_q   <= req_data_i;
                nib_q    <= (MEM_EN && req_mem_i) ? 3'd7 : 3'd3;
                status_q <= ST_OK;
                rdata_q  <= '0;
            end

            if (state_q == S_ADDR) begin
                nib_q <= nib_q - 3'd1;
            end

            // Counters restart on every entry to SYNC because they are held clear outside it.
            if (state_q != S_SYNC) begin
                swait_q  <= '0;
                lwait_q  <= '0;
                noresp_q <= '0;
            end else begin
                if (sync_short && !abort_tmo) begin
                    swait_q  <= swait_q + 1'b1;
                    noresp_q <= '0;
                end
                if (sync_long && !abort_tmo) begin
                    lwait_q  <= lwait_q + 1'b1;
                    noresp_q <= '0;
                end
                if (sync_bad && !abort_noresp) begin
                    noresp_q <= noresp_q + 1'b1;
                end
                if (sync_err) begin
                    status_q <= ST_SYNERR;
                end
                if (abort_noresp) begin
                    status_q <= ST_NORESP;
                end
                if (abort_tmo) begin
                    status_q <= ST_TMO;
                end
            end

            if (state_q == S_RD_LO) begin
                rdata_q[3:0] <= lad_i;
            end
            if (state_q == S_RD_HI) begin
                rdata_q[7:4] <= lad_i;
            end

            if (state_q == S_ABORT) begin
                abort_cnt_q <= abort_cnt_q + 1'b1;
            end else begin
                abort_cnt_q <= '0;
            end

            // Aborts leave rdata_q at its cleared value, so only writes need forcing to zero.
            if (load_rsp) begin
                rsp_data_q   <= write_q ? 8'h00 : rdata_q;
                rsp_status_q <= status_q;
            end
        end
    end

endmodule

// File: tb/tb_lpc_host_ctrl.sv
// tb/tb_lpc_host_ctrl.sv - directed bench for lpc_host_ctrl with a behavioural LPC peripheral
module tb_lpc_host_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic        req_mem_i;
    logic        req_tpm_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic [1:0]  rsp_status_o;
    logic        busy_o;
    logic        lframe_o;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic [3:0]  lad_i;

    lpc_host_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_mem_i    (req_mem_i),
        .req_tpm_i    (req_tpm_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .busy_o       (busy_o),
        .lframe_o     (lframe_o),
        .lad_o        (lad_o),
        .lad_oe_o     (lad_oe_o),
        .lad_i        (lad_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pmem [16];
    logic [3:0] obs_lad [64];
    logic       obs_oe  [64];
    logic       obs_lf  [64];

    typedef struct {
        logic        wr;
        logic        mem;
        logic        tpm;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [3:0]  wait_nib;
        int          n_wait;
        logic [3:0]  final_nib;
        logic [1:0]  exp_st;
        logic [7:0]  exp_data;
        int          exp_lat;
        int          exp_lf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request and act as the peripheral: SYNC script = n_wait x wait_nib then final_nib.
    task automatic run_txn(input logic wr, input logic mem, input logic tpm,
                           input logic [31:0] addr, input logic [7:0] data,
                           input logic [3:0] wait_nib, input int n_wait, input logic [3:0] final_nib,
                           output logic [1:0] st, output logic [7:0] dat,
                           output int lat, output int lf_low);
        int k, na, sync_k, off;
        logic [3:0] wlo, whi;
        logic [7:0] rv;
        bit done;
        na = mem ? 8 : 4;
        sync_k = 5 + na + (wr ? 2 : 0);
        st = '0; dat = '0; lat = -1; lf_low = 0; done = 0; wlo = '0; whi = '0;
        rv = pmem[addr[3:0]];
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_mem_i   = mem;
        req_tpm_i   = tpm;
        req_addr_i  = addr;
        req_data_i  = data;
        check("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 1;
        while (!done && k <= 2000) begin
            off = k - sync_k;
            if (k < sync_k) lad_i = 4'hF;
            else if (off < n_wait) lad_i = wait_nib;
            else if (off == n_wait) lad_i = final_nib;
            else if (!wr && off == n_wait + 1) lad_i = rv[3:0];
            else if (!wr && off == n_wait + 2) lad_i = rv[7:4];
            else lad_i = 4'hF;
            if (k < 64) begin
                obs_lad[k] = lad_o;
                obs_oe[k]  = lad_oe_o;
                obs_lf[k]  = lframe_o;
            end
            if (k > 1 && !lframe_o) lf_low++;
            if (wr && k == 3 + na) wlo = lad_o;
            if (wr && k == 4 + na) whi = lad_o;
            if (rsp_valid_o) begin
                done = 1;
                lat  = k - 1;
                st   = rsp_status_o;
                dat  = rsp_data_o;
            end else begin
                @(negedge clk_i);
                k++;
            end
        end
        lad_i = 4'hF;
        check("txn_completes", {31'd0, done}, 32'd1);
        if (done && wr && st == 2'b00) pmem[addr[3:0]] = {whi, wlo};
    endtask

    initial begin
        logic [1:0] st;
        logic [7:0] dat;
        int lat, lf, rsp_seen;
        logic [3:0] exp_nib [10];

        for (int i = 0; i < 16; i++) pmem[i] = 8'h00;
        pmem[0] = 8'h3C;
        pmem[1] = 8'h81;
        pmem[2] = 8'h77;

        //          wr    mem   tpm   addr          data   wnib  nw    fin   st     data   lat   lf
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'h00, 4'h5, 0,    4'h0, 2'b00, 8'h3C, 13,   0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0001, 8'h00, 4'h5, 32,   4'h0, 2'b00, 8'h81, 45,   0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 8'hC3, 4'h5, 33,   4'h0, 2'b11, 8'h00, 48,   4};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_0001, 8'h00, 4'h6, 1024, 4'h0, 2'b00, 8'h81, 1037, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0002, 8'h00, 4'h6, 1025, 4'h0, 2'b11, 8'h00, 1038, 4};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'h00, 4'hF, 3,    4'hF, 2'b10, 8'h00, 16,   4};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0002, 8'h00, 4'hF, 2,    4'h0, 2'b00, 8'h77, 15,   0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0000_0002, 8'h00, 4'h5, 0,    4'hA, 2'b01, 8'h77, 13,   0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h1234_5677, 8'h3C, 4'h5, 0,    4'h0, 2'b00, 8'h00, 17,   0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 32'h0000_0007, 8'h00, 4'h5, 0,    4'h0, 2'b00, 8'h3C, 17,   0};

        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_mem_i = 1'b0;
        req_tpm_i = 1'b0; req_addr_i = '0; req_data_i = '0; lad_i = 4'hF;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_lframe", {31'd0, lframe_o}, 32'd1);
        check("rst_lad_oe", {31'd0, lad_oe_o}, 32'd0);
        check("rst_lad", {28'd0, lad_o}, 32'hF);
        check("rst_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data_o}, 32'h00);
        check("rst_rsp_status", {30'd0, rsp_status_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].wr, vecs[i].mem, vecs[i].tpm, vecs[i].addr, vecs[i].data,
                    vecs[i].wait_nib, vecs[i].n_wait, vecs[i].final_nib, st, dat, lat, lf);
            check($sformatf("vec%0d_status", i), {30'd0, st}, {30'd0, vecs[i].exp_st});
            check($sformatf("vec%0d_data", i), {24'd0, dat}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_lframe_low", i), lf, vecs[i].exp_lf);
        end

        // TPM-start I/O write: exact LAD nibble stream, then readback through the peripheral model.
        run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0008, 8'hA5, 4'h5, 0, 4'h0, st, dat, lat, lf);
        exp_nib[1] = 4'h5; exp_nib[2] = 4'h2; exp_nib[3] = 4'h0; exp_nib[4] = 4'h0;
        exp_nib[5] = 4'h0; exp_nib[6] = 4'h8; exp_nib[7] = 4'h5; exp_nib[8] = 4'hA;
        exp_nib[9] = 4'hF;
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("tpmwr_lad_k%0d", k), {28'd0, obs_lad[k]}, {28'd0, exp_nib[k]});
            check($sformatf("tpmwr_oe_k%0d", k), {31'd0, obs_oe[k]}, 32'd1);
        end
        check("tpmwr_oe_tar2", {31'd0, obs_oe[10]}, 32'd0);
        check("tpmwr_lframe_start", {31'd0, obs_lf[1]}, 32'd0);
        check("tpmwr_lframe_cycdir", {31'd0, obs_lf[2]}, 32'd1);
        check("tpmwr_status", {30'd0, st}, 32'd0);
        check("tpmwr_latency", lat, 13);
        run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0008, 8'h00, 4'h5, 0, 4'h0, st, dat, lat, lf);
        check("readback_data", {24'd0, dat}, 32'hA5);
        check("readback_status", {30'd0, st}, 32'd0);
        repeat (3) @(negedge clk_i);
        check("rsp_data_held", {24'd0, rsp_data_o}, 32'hA5);
        check("rsp_valid_one_cycle", {31'd0, rsp_valid_o}, 32'd0);

        // Memory read with three short waits: CYCDIR and eight address nibbles MSB first.
        run_txn(1'b0, 1'b1, 1'b0, 32'hFED4_0000, 8'h00, 4'h5, 3, 4'h0, st, dat, lat, lf);
        exp_nib[2] = 4'h4; exp_nib[3] = 4'hF; exp_nib[4] = 4'hE; exp_nib[5] = 4'hD;
        exp_nib[6] = 4'h4; exp_nib[7] = 4'h0; exp_nib[8] = 4'h0; exp_nib[9] = 4'h0;
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("memrd_lad_k%0d", k), {28'd0, obs_lad[k]}, {28'd0, exp_nib[k]});
        end
        check("memrd_lad_k10", {28'd0, obs_lad[10]}, 32'h0);
        check("memrd_latency", lat, 20);
        check("memrd_status", {30'd0, st}, 32'd0);
        check("memrd_data", {24'd0, dat}, 32'h3C);

        // Reset in the middle of a write's address phase.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_mem_i = 1'b0; req_tpm_i = 1'b0;
        req_addr_i = 32'h0000_0003; req_data_i = 8'h11;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("midrst_in_addr_oe", {31'd0, lad_oe_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_lframe", {31'd0, lframe_o}, 32'd1);
        check("midrst_lad_oe", {31'd0, lad_oe_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_rsp_data", {24'd0, rsp_data_o}, 32'h00);
        rst_i = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) rsp_seen++;
        end
        check("midrst_no_rsp", rsp_seen, 0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0003, 8'h11, 4'h5, 0, 4'h0, st, dat, lat, lf);
        check("postrst_wr_status", {30'd0, st}, 32'd0);
        check("postrst_wr_latency", lat, 13);
        run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0003, 8'h00, 4'h5, 0, 4'h0, st, dat, lat, lf);
        check("postrst_rd_data", {24'd0, dat}, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
